// File: rtl/fbs_pkg.sv
// Shared types and constants for the triple-buffer frame scheduler.
package fbs_pkg;

    typedef logic [1:0] buf_idx_t;

    localparam buf_idx_t IDX_W0 = 2'd0;
    localparam buf_idx_t IDX_P0 = 2'd1;
    localparam buf_idx_t IDX_R0 = 2'd2;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wr_state_e;

    localparam int CNT_W  = 16;
    localparam int LINE_W = 11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fbs_edge_sync.sv
// Async pin -> 2-flop sync -> edge register; 1-cycle start/end pulses 3 cycles after the pin edge.
// Pulses are held off until the chain has seen the real pin, so a level already active at reset release is no edge.
module fbs_edge_sync #(
    parameter bit POL = 1'b1
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic pin_i,
    output logic start_o,
    output logic end_o
);

    logic       s1_q, s2_q, act_prev_q, start_q, end_q;
    logic [1:0] warm_q;
    logic       act, armed;

    assign act   = (s2_q == POL);
    assign armed = (warm_q == 2'd3);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_q       <= !POL;
            s2_q       <= !POL;
            act_prev_q <= 1'b0;
            warm_q     <= 2'd0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            s1_q       <= pin_i;
            s2_q       <= s1_q;
            act_prev_q <= act;
            if (!armed) warm_q <= warm_q + 2'd1;
            start_q    <= armed && act && !act_prev_q;
            end_q      <= armed && !act && act_prev_q;
        end
    end

    assign start_o = start_q;
    assign end_o   = end_q;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer rotation between camera writer and VGA reader over three SDRAM frame regions.
// Base address and LOAD pulse appear 1 cycle after the synchronized edge pulse.
module frame_buffer_scheduler
    import fbs_pkg::*;
#(
    parameter int FRAME_WORDS = 307200,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 23,
    parameter int MIN_LINES   = 480,
    parameter bit WR_VS_POL   = 1'b1,
    parameter bit RD_VS_POL   = 1'b0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iWR_VS,
    input  logic              iWR_HS,
    input  logic              iRD_VS,
    input  logic              iFREEZE,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic              oWR_LOAD,
    output logic              oRD_LOAD,
    output logic [CNT_W-1:0]  oDROP_CNT,
    output logic [CNT_W-1:0]  oSHORT_CNT,
    output logic [1:0]        oWR_IDX,
    output logic [1:0]        oRD_IDX
);

    localparam logic [ADDR_W-1:0] ADDR0 = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR1 = ADDR_W'(BASE_ADDR + FRAME_WORDS);
    localparam logic [ADDR_W-1:0] ADDR2 = ADDR_W'(BASE_ADDR + 2 * FRAME_WORDS);
    localparam logic [LINE_W-1:0] MIN_L = LINE_W'(MIN_LINES);

    function automatic logic [ADDR_W-1:0] idx_addr(input buf_idx_t i);
        case (i)
            2'd0:    return ADDR0;
            2'd1:    return ADDR1;
            default: return ADDR2;
        endcase
    endfunction

    logic wr_start, wr_end, hs_start, hs_end, rd_start, rd_end;
    logic unused_edges;
    assign unused_edges = hs_end ^ rd_end;

    fbs_edge_sync #(.POL(WR_VS_POL)) u_wr_vs (
        .iCLK(iCLK), .iRST(iRST), .pin_i(iWR_VS), .start_o(wr_start), .end_o(wr_end));
    fbs_edge_sync #(.POL(1'b1)) u_wr_hs (
        .iCLK(iCLK), .iRST(iRST), .pin_i(iWR_HS), .start_o(hs_start), .end_o(hs_end));
    fbs_edge_sync #(.POL(RD_VS_POL)) u_rd_vs (
        .iCLK(iCLK), .iRST(iRST), .pin_i(iRD_VS), .start_o(rd_start), .end_o(rd_end));

    wr_state_e          state_q, state_d;
    buf_idx_t           widx_q, widx_d, pidx_q, pidx_d, ridx_q, ridx_d;
    logic               fresh_q, fresh_d;
    logic [LINE_W-1:0]  lines_q, lines_d;
    logic [CNT_W-1:0]   drop_q, drop_d, short_q, short_d;
    logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
    logic               wr_load_q, rd_load_q;
    logic               commit, rd_swap;

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        pidx_d  = pidx_q;
        ridx_d  = ridx_q;
        fresh_d = fresh_q;
        lines_d = lines_q;
        drop_d  = drop_q;
        short_d = short_q;
        commit  = 1'b0;
        rd_swap = 1'b0;

        case (state_q)
            W_IDLE: begin
                if (wr_start) begin
                    state_d = W_ACTIVE;
                    lines_d = '0;
                end
            end
            W_ACTIVE: begin
                if (wr_start) begin
                    lines_d = '0;
                end else if (wr_end) begin
                    state_d = W_IDLE;
                    if (lines_q >= MIN_L) commit = 1'b1;
                    else short_d = sat_inc(short_q);
                end else if (hs_start && lines_q != '1) begin
                    lines_d = lines_q + LINE_W'(1);
                end
            end
            default: state_d = W_IDLE;
        endcase

        // Commit first, then the reader swap sees the post-commit pending buffer.
        if (commit) begin
            widx_d  = pidx_q;
            pidx_d  = widx_q;
            fresh_d = 1'b1;
        end
        rd_swap = rd_start && fresh_d && !iFREEZE;
        if (rd_swap) begin
            ridx_d  = pidx_d;
            pidx_d  = ridx_q;
            fresh_d = 1'b0;
        end
        if (commit && fresh_q && !rd_swap) drop_d = sat_inc(drop_q);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= W_IDLE;
            widx_q    <= IDX_W0;
            pidx_q    <= IDX_P0;
            ridx_q    <= IDX_R0;
            fresh_q   <= 1'b0;
            lines_q   <= '0;
            drop_q    <= '0;
            short_q   <= '0;
            wr_addr_q <= ADDR0;
            rd_addr_q <= ADDR2;
            wr_load_q <= 1'b0;
            rd_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            pidx_q    <= pidx_d;
            ridx_q    <= ridx_d;
            fresh_q   <= fresh_d;
            lines_q   <= lines_d;
            drop_q    <= drop_d;
            short_q   <= short_d;
            wr_addr_q <= idx_addr(widx_d);
            rd_addr_q <= idx_addr(ridx_d);
            wr_load_q <= (widx_d != widx_q);
            rd_load_q <= (ridx_d != ridx_q);
        end
    end

    assign oWR_ADDR   = wr_addr_q;
    assign oRD_ADDR   = rd_addr_q;
    assign oWR_LOAD   = wr_load_q;
    assign oRD_LOAD   = rd_load_q;
    assign oDROP_CNT  = drop_q;
    assign oSHORT_CNT = short_q;
    assign oWR_IDX    = widx_q;
    assign oRD_IDX    = ridx_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with hand-computed buffer rotations.
module tb_frame_buffer_scheduler;

    logic        iCLK = 1'b0;
    logic        iRST, iWR_VS, iWR_HS, iRD_VS, iFREEZE;
    logic [22:0] oWR_ADDR, oRD_ADDR;
    logic        oWR_LOAD, oRD_LOAD;
    logic [15:0] oDROP_CNT, oSHORT_CNT;
    logic [1:0]  oWR_IDX, oRD_IDX;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_loads = 0;
    int rd_loads = 0;
    int wl0, rl0;

    frame_buffer_scheduler dut (
        .iCLK(iCLK), .iRST(iRST), .iWR_VS(iWR_VS), .iWR_HS(iWR_HS),
        .iRD_VS(iRD_VS), .iFREEZE(iFREEZE),
        .oWR_ADDR(oWR_ADDR), .oRD_ADDR(oRD_ADDR),
        .oWR_LOAD(oWR_LOAD), .oRD_LOAD(oRD_LOAD),
        .oDROP_CNT(oDROP_CNT), .oSHORT_CNT(oSHORT_CNT),
        .oWR_IDX(oWR_IDX), .oRD_IDX(oRD_IDX)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (oWR_LOAD) wr_loads <= wr_loads + 1;
        if (oRD_LOAD) rd_loads <= rd_loads + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic write_lines(input int n);
        for (int i = 0; i < n; i++) begin
            iWR_HS = 1'b1; cyc(3);
            iWR_HS = 1'b0; cyc(3);
        end
    endtask

    task automatic write_frame(input int n, input bit rd_at_end);
        iWR_VS = 1'b1; cyc(5);
        write_lines(n);
        iWR_VS = 1'b0;
        if (rd_at_end) iRD_VS = 1'b0;
        cyc(4);
        iRD_VS = 1'b1;
        cyc(8);
    endtask

    task automatic rd_pulse();
        iRD_VS = 1'b0; cyc(4);
        iRD_VS = 1'b1; cyc(8);
    endtask

    task automatic do_reset();
        iRST = 1'b1; cyc(3);
        iRST = 1'b0; cyc(5);
    endtask

    task automatic test_reset();
        iWR_VS = 1'b0; iWR_HS = 1'b0; iRD_VS = 1'b1; iFREEZE = 1'b0;
        do_reset();
        wl0 = wr_loads; rl0 = rd_loads;
        cyc(10);
        n_cmp++; if (oWR_ADDR !== 23'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %0d expected 0", oWR_ADDR); end
        n_cmp++; if (oRD_ADDR !== 23'd614400) begin n_bad++; $display("FAIL reset_rd_addr: got %0d expected 614400", oRD_ADDR); end
        n_cmp++; if (oWR_IDX !== 2'd0 || oRD_IDX !== 2'd2) begin n_bad++; $display("FAIL reset_idx: got %0d/%0d expected 0/2", oWR_IDX, oRD_IDX); end
        n_cmp++; if (oDROP_CNT !== 16'd0 || oSHORT_CNT !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", oDROP_CNT, oSHORT_CNT); end
        n_cmp++; if (wr_loads != wl0 || rd_loads != rl0 || oWR_LOAD !== 1'b0 || oRD_LOAD !== 1'b0) begin n_bad++; $display("FAIL reset_loads: got %0d/%0d pulses expected 0/0", wr_loads - wl0, rd_loads - rl0); end
    endtask

    task automatic test_single_frame();
        wl0 = wr_loads; rl0 = rd_loads;
        write_frame(480, 1'b0);
        n_cmp++; if (oWR_ADDR !== 23'd307200 || oWR_IDX !== 2'd1) begin n_bad++; $display("FAIL commit_wr: got idx %0d addr %0d expected 1/307200", oWR_IDX, oWR_ADDR); end
        n_cmp++; if (wr_loads - wl0 != 1) begin n_bad++; $display("FAIL commit_wr_load: got %0d pulses expected 1", wr_loads - wl0); end
        n_cmp++; if (rd_loads - rl0 != 0 || oRD_IDX !== 2'd2) begin n_bad++; $display("FAIL commit_rd_quiet: got %0d pulses idx %0d expected 0/2", rd_loads - rl0, oRD_IDX); end
        rd_pulse();
        n_cmp++; if (oRD_ADDR !== 23'd0 || oRD_IDX !== 2'd0) begin n_bad++; $display("FAIL rd_swap: got idx %0d addr %0d expected 0/0", oRD_IDX, oRD_ADDR); end
        n_cmp++; if (rd_loads - rl0 != 1 || wr_loads - wl0 != 1) begin n_bad++; $display("FAIL rd_swap_load: got %0d rd / %0d wr pulses expected 1/1", rd_loads - rl0, wr_loads - wl0); end
    endtask

    task automatic test_back_to_back();
        write_frame(480, 1'b0);
        write_frame(480, 1'b0);
        n_cmp++; if (oDROP_CNT !== 16'd1) begin n_bad++; $display("FAIL drop_cnt: got %0d expected 1", oDROP_CNT); end
        n_cmp++; if (oWR_IDX !== 2'd1) begin n_bad++; $display("FAIL b2b_wr_idx: got %0d expected 1", oWR_IDX); end
        rd_pulse();
        n_cmp++; if (oRD_IDX !== 2'd2 || oRD_ADDR !== 23'd614400) begin n_bad++; $display("FAIL b2b_rd: got idx %0d addr %0d expected 2/614400", oRD_IDX, oRD_ADDR); end
    endtask

    task automatic test_short_frame();
        wl0 = wr_loads;
        write_frame(100, 1'b0);
        n_cmp++; if (oSHORT_CNT !== 16'd1) begin n_bad++; $display("FAIL short_cnt: got %0d expected 1", oSHORT_CNT); end
        n_cmp++; if (oWR_ADDR !== 23'd307200 || oWR_IDX !== 2'd1) begin n_bad++; $display("FAIL short_wr_hold: got idx %0d addr %0d expected 1/307200", oWR_IDX, oWR_ADDR); end
        n_cmp++; if (wr_loads != wl0 || oDROP_CNT !== 16'd1) begin n_bad++; $display("FAIL short_no_load: got %0d pulses drop %0d expected 0/1", wr_loads - wl0, oDROP_CNT); end
    endtask

    task automatic test_simultaneous();
        write_frame(480, 1'b0);
        n_cmp++; if (oWR_IDX !== 2'd0) begin n_bad++; $display("FAIL sim_pre_commit: got %0d expected 0", oWR_IDX); end
        rl0 = rd_loads;
        write_frame(480, 1'b1);
        n_cmp++; if (oRD_IDX !== 2'd0 || oRD_ADDR !== 23'd0) begin n_bad++; $display("FAIL sim_rd: got idx %0d addr %0d expected 0/0", oRD_IDX, oRD_ADDR); end
        n_cmp++; if (oWR_IDX !== 2'd1 || oWR_ADDR !== 23'd307200) begin n_bad++; $display("FAIL sim_wr: got idx %0d addr %0d expected 1/307200", oWR_IDX, oWR_ADDR); end
        n_cmp++; if (oDROP_CNT !== 16'd1) begin n_bad++; $display("FAIL sim_drop: got %0d expected 1", oDROP_CNT); end
        n_cmp++; if (oWR_IDX == oRD_IDX || oWR_IDX > 2'd2 || oRD_IDX > 2'd2) begin n_bad++; $display("FAIL sim_perm: got wr %0d rd %0d expected distinct in 0..2", oWR_IDX, oRD_IDX); end
        n_cmp++; if (rd_loads - rl0 != 1) begin n_bad++; $display("FAIL sim_rd_load: got %0d expected 1", rd_loads - rl0); end
        rd_pulse();
        n_cmp++; if (oRD_IDX !== 2'd0 || rd_loads - rl0 != 1) begin n_bad++; $display("FAIL sim_repeat: got idx %0d pulses %0d expected 0/1", oRD_IDX, rd_loads - rl0); end
    endtask

    task automatic test_freeze();
        do_reset();
        rl0 = rd_loads;
        iFREEZE = 1'b1;
        for (int f = 0; f < 3; f++) begin
            write_frame(480, 1'b0);
            rd_pulse();
            n_cmp++; if (oRD_ADDR !== 23'd614400) begin n_bad++; $display("FAIL freeze_rd_addr: frame %0d got %0d expected 614400", f, oRD_ADDR); end
        end
        n_cmp++; if (rd_loads != rl0) begin n_bad++; $display("FAIL freeze_no_load: got %0d expected 0", rd_loads - rl0); end
        n_cmp++; if (oDROP_CNT !== 16'd2) begin n_bad++; $display("FAIL freeze_drop: got %0d expected 2", oDROP_CNT); end
        n_cmp++; if (oWR_IDX !== 2'd1) begin n_bad++; $display("FAIL freeze_wr_idx: got %0d expected 1", oWR_IDX); end
        iFREEZE = 1'b0;
        rd_pulse();
        n_cmp++; if (oRD_IDX !== 2'd0 || oRD_ADDR !== 23'd0) begin n_bad++; $display("FAIL unfreeze_rd: got idx %0d addr %0d expected 0/0", oRD_IDX, oRD_ADDR); end
    endtask

    task automatic test_reset_mid_frame();
        iWR_VS = 1'b1; cyc(5);
        write_lines(50);
        iRST = 1'b1; cyc(3);
        iRST = 1'b0; cyc(5);
        wl0 = wr_loads;
        write_lines(5);
        iWR_VS = 1'b0; cyc(10);
        n_cmp++; if (oDROP_CNT !== 16'd0 || oSHORT_CNT !== 16'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d/%0d expected 0/0", oDROP_CNT, oSHORT_CNT); end
        n_cmp++; if (oWR_IDX !== 2'd0 || oRD_IDX !== 2'd2 || oWR_ADDR !== 23'd0) begin n_bad++; $display("FAIL midrst_idx: got %0d/%0d addr %0d expected 0/2/0", oWR_IDX, oRD_IDX, oWR_ADDR); end
        n_cmp++; if (wr_loads != wl0) begin n_bad++; $display("FAIL midrst_no_load: got %0d expected 0", wr_loads - wl0); end
        write_frame(480, 1'b0);
        n_cmp++; if (oWR_IDX !== 2'd1) begin n_bad++; $display("FAIL midrst_recover: got %0d expected 1", oWR_IDX); end
    endtask

    initial begin
        iRST = 1'b1; iWR_VS = 1'b0; iWR_HS = 1'b0; iRD_VS = 1'b1; iFREEZE = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_simultaneous();
        test_freeze();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
